// File: rtl/pal_cfg_loader.sv
// Byte-to-serial loader for the PAL configuration shift chain; LSB of each byte shifts first.
// Optional CRC-8 trailer check is enabled by defining PAL_CFG_CRC_EN.
module pal_cfg_loader #(
    parameter int NUM_INPUTS        = 8,
    parameter int NUM_INTERM_STAGES = 11,
    parameter int NUM_OUTPUTS       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       enable_req,
    output logic       cfg_bit,
    output logic       cfg_shift,
    output logic       pal_enable,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int BITSTREAM_LEN = 2*NUM_INPUTS*NUM_INTERM_STAGES + NUM_INTERM_STAGES*NUM_OUTPUTS;
    localparam int CNT_W         = $clog2(BITSTREAM_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITSTREAM_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
`ifdef PAL_CFG_CRC_EN
        , S_CHECK,
        S_ERR
`endif
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shreg_q;
    logic             byte_ready_q;
    logic             cfg_bit_q;
    logic             cfg_shift_q;
    logic             pal_enable_q;
    logic             busy_q;
    logic             done_q;

`ifdef PAL_CFG_CRC_EN
    logic [7:0] crc_q;
    logic       error_q;

    // CRC-8, poly 0x07, MSB-first register, one chain bit per call
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            byte_ready_q <= 1'b0;
            cfg_bit_q    <= 1'b0;
            cfg_shift_q  <= 1'b0;
            pal_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef PAL_CFG_CRC_EN
            crc_q        <= '0;
            error_q      <= 1'b0;
`endif
        end else if (abort) begin
            // chain keeps whatever was already shifted in
            state_q      <= S_IDLE;
            byte_ready_q <= 1'b0;
            cfg_bit_q    <= 1'b0;
            cfg_shift_q  <= 1'b0;
            pal_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef PAL_CFG_CRC_EN
            error_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q      <= S_LOAD;
                        bit_cnt_q    <= '0;
                        busy_q       <= 1'b1;
                        byte_ready_q <= 1'b1;
`ifdef PAL_CFG_CRC_EN
                        crc_q        <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (byte_valid && byte_ready_q) begin
                        state_q      <= S_SHIFT;
                        shreg_q      <= {1'b0, byte_in[7:1]};
                        cfg_bit_q    <= byte_in[0];
                        cfg_shift_q  <= 1'b1;
                        byte_ready_q <= 1'b0;
                        bit_idx_q    <= '0;
                    end
                end
                S_SHIFT: begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
`ifdef PAL_CFG_CRC_EN
                    crc_q     <= crc8_step(crc_q, cfg_bit_q);
`endif
                    if (bit_cnt_q == LAST_BIT) begin
                        // chain full: remaining bits of this byte are dropped
                        cfg_shift_q <= 1'b0;
                        cfg_bit_q   <= 1'b0;
`ifdef PAL_CFG_CRC_EN
                        state_q      <= S_CHECK;
                        byte_ready_q <= 1'b1;
`else
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
`endif
                    end else if (bit_idx_q == 3'd7) begin
                        state_q      <= S_LOAD;
                        cfg_shift_q  <= 1'b0;
                        cfg_bit_q    <= 1'b0;
                        byte_ready_q <= 1'b1;
                    end else begin
                        cfg_bit_q <= shreg_q[0];
                        shreg_q   <= shreg_q >> 1;
                        bit_idx_q <= bit_idx_q + 3'd1;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_q      <= S_LOAD;
                        bit_cnt_q    <= '0;
                        busy_q       <= 1'b1;
                        byte_ready_q <= 1'b1;
                        done_q       <= 1'b0;
                        pal_enable_q <= 1'b0;
`ifdef PAL_CFG_CRC_EN
                        crc_q        <= '0;
`endif
                    end else begin
                        pal_enable_q <= enable_req;
                    end
                end
`ifdef PAL_CFG_CRC_EN
                S_CHECK: begin
                    // trailer byte is compared, never shifted
                    if (byte_valid) begin
                        byte_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                        if (byte_in == crc_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                S_ERR: begin
                    if (start) begin
                        state_q      <= S_LOAD;
                        bit_cnt_q    <= '0;
                        busy_q       <= 1'b1;
                        byte_ready_q <= 1'b1;
                        error_q      <= 1'b0;
                        crc_q        <= '0;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign cfg_bit    = cfg_bit_q;
    assign cfg_shift  = cfg_shift_q;
    assign pal_enable = pal_enable_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef PAL_CFG_CRC_EN
    assign error      = error_q;
`else
    assign error      = 1'b0;
`endif

endmodule
